// File: rtl/ft_pkg.sv
// Shared fault-tolerance definitions: replay FSM states and default widths,
// used by the replay unit and the recovery controller.
package ft_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COPY_PC  = 3'd1,
    COPY_GPR = 3'd2,
    DRAIN    = 3'd3,
    WAIT_RES = 3'd4,
    RELEASE  = 3'd5
  } replay_state_e;

endpackage

// File: rtl/replay_seq_check.sv
// Replay ordering checker: tracks the register index the controller should
// present next and raises a sticky flag on any protocol violation.
module replay_seq_check
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  cnt_clr_i,
  input  logic                  cnt_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  early_resume_i,
  output logic                  seq_err_o
);

  // One extra bit so the count after the last register does not wrap to 0.
  logic [ADDR_WIDTH:0] exp_cnt_q;
  logic                mismatch;

  assign mismatch = cnt_en_i && ({1'b0, addr_i} != exp_cnt_q);

  // Expected index: zeroed just before the copy starts, advances every copy cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_cnt_q <= '0;
    end else if (cnt_clr_i) begin
      exp_cnt_q <= '0;
    end else if (cnt_en_i) begin
      exp_cnt_q <= exp_cnt_q + 1'b1;
    end
  end

  // Sticky error: cleared when a new recovery starts, set on any violation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seq_err_o <= 1'b0;
    end else if (start_i) begin
      seq_err_o <= 1'b0;
    end else if (mismatch || early_resume_i) begin
      seq_err_o <= 1'b1;
    end
  end

endmodule

// File: rtl/replay_unit.sv
// Checkpoint replay unit: halts the target core, restores its PC and register
// file from the checkpoint copy, then releases it on the controller's resume.
module replay_unit
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  halt_i,
  input  logic                  shift_i,
  input  logic                  resume_i,
  input  logic [ADDR_WIDTH-1:0] replay_addr_i,
  output logic [ADDR_WIDTH-1:0] ckpt_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] ckpt_rd_data_i,
  input  logic [DATA_WIDTH-1:0] ckpt_pc_i,
  output logic                  pc_we_o,
  output logic [DATA_WIDTH-1:0] pc_wdata_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  core_halt_o,
  output logic                  done_o,
  output logic                  seq_err_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  replay_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic                  vld_p0;
  logic                  resume_pend_q;
  logic                  start;
  logic                  early_resume;

  assign start        = (state_q == IDLE) && halt_i && shift_i;
  assign early_resume = resume_i && ((state_q == COPY_PC) ||
                                     (state_q == COPY_GPR) ||
                                     (state_q == DRAIN));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and command outputs; halt and resume are only honoured in
  // IDLE and WAIT_RES respectively.
  always_comb begin
    state_d        = state_q;
    core_halt_o    = 1'b0;
    pc_we_o        = 1'b0;
    pc_wdata_o     = '0;
    ckpt_rd_addr_o = '0;
    done_o         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = COPY_PC;
      end
      COPY_PC: begin
        core_halt_o = 1'b1;
        pc_we_o     = 1'b1;
        pc_wdata_o  = ckpt_pc_i;
        state_d     = COPY_GPR;
      end
      COPY_GPR: begin
        core_halt_o    = 1'b1;
        ckpt_rd_addr_o = replay_addr_i;
        if (replay_addr_i == LAST_ADDR) state_d = DRAIN;
      end
      DRAIN: begin
        core_halt_o = 1'b1;
        state_d     = WAIT_RES;
      end
      WAIT_RES: begin
        core_halt_o = 1'b1;
        if (resume_i || resume_pend_q) state_d = RELEASE;
      end
      RELEASE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: the presented address is held one cycle to line up with the
  // checkpoint read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= (state_q == COPY_GPR);
    end
  end

  // Address capture for the stage p0 write (data only, qualified by vld_p0).
  always_ff @(posedge clk_i) begin
    if (state_q == COPY_GPR) addr_p0 <= replay_addr_i;
  end

  // Register 0 is hardwired in the core, so its write is dropped.
  assign rf_we_o    = vld_p0 && (addr_p0 != '0);
  assign rf_waddr_o = vld_p0 ? addr_p0 : '0;
  assign rf_wdata_o = vld_p0 ? ckpt_rd_data_i : '0;

  // Resume seen before the copy finished is remembered for WAIT_RES.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resume_pend_q <= 1'b0;
    end else if (start || (state_q == RELEASE)) begin
      resume_pend_q <= 1'b0;
    end else if (early_resume) begin
      resume_pend_q <= 1'b1;
    end
  end

  replay_seq_check #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_seq_check (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start),
    .cnt_clr_i      (state_q == COPY_PC),
    .cnt_en_i       (state_q == COPY_GPR),
    .addr_i         (replay_addr_i),
    .early_resume_i (early_resume),
    .seq_err_o      (seq_err_o)
  );

endmodule

// File: doc/replay_unit.md
REPLAY_UNIT -- requirements
Module: replay_unit

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 5, the register-file address width (NUM_REG = 2**ADDR_WIDTH).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, the register and PC data width.
REQ-003 The module SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_ni, input, 1 bit, the asynchronous active-low reset.
REQ-005 The module SHALL have ports halt_i, shift_i and resume_i, each input, 1 bit, the recovery-controller commands.
REQ-006 The module SHALL have port replay_addr_i, input, ADDR_WIDTH bits, the controller's register index being replayed.
REQ-007 The module SHALL have port ckpt_rd_addr_o, output, ADDR_WIDTH bits, the checkpoint register-file read address; data returns on ckpt_rd_data_i (input, DATA_WIDTH bits) one cycle later.
REQ-008 The module SHALL have port ckpt_pc_i, input, DATA_WIDTH bits, the checkpointed PC.
REQ-009 The module SHALL have ports pc_we_o (output, 1 bit) and pc_wdata_o (output, DATA_WIDTH bits), the target-core PC write.
REQ-010 The module SHALL have ports rf_we_o (output, 1 bit), rf_waddr_o (output, ADDR_WIDTH bits) and rf_wdata_o (output, DATA_WIDTH bits), the target register-file write.
REQ-011 The module SHALL have port core_halt_o, output, 1 bit, the target-core stall.
REQ-012 The module SHALL have port done_o, output, 1 bit, a one-cycle pulse when recovery completes.
REQ-013 The module SHALL have port seq_err_o, output, 1 bit, a sticky protocol-violation flag.

Function
REQ-014 The FSM SHALL have states IDLE, COPY_PC, COPY_GPR, DRAIN, WAIT_RES and RELEASE.
REQ-015 In IDLE, halt_i=1 with shift_i=1 SHALL move the FSM to COPY_PC, set core_halt_o=1 and clear seq_err_o; halt_i without shift_i SHALL be ignored.
REQ-016 COPY_PC SHALL last exactly one cycle, driving pc_we_o=1 and pc_wdata_o=ckpt_pc_i, then go to COPY_GPR.
REQ-017 In COPY_GPR, ckpt_rd_addr_o SHALL equal replay_addr_i (combinational) each cycle.
REQ-018 In COPY_GPR, replay_addr_i SHALL be registered so that the next cycle drives rf_we_o=1, rf_waddr_o=that address and rf_wdata_o=ckpt_rd_data_i.
REQ-019 Each register SHALL therefore be written one cycle after its address is presented.
REQ-020 Writes to address 0 SHALL be suppressed (rf_we_o=0).
REQ-021 An internal expected counter SHALL start at 0 on entry to COPY_GPR and increment each COPY_GPR cycle.
REQ-022 Whenever replay_addr_i differs from the expected counter in COPY_GPR, seq_err_o SHALL be set and the presented address SHALL still be copied.
REQ-023 When replay_addr_i = NUM_REG-1 is captured, the FSM SHALL go to DRAIN.
REQ-024 DRAIN SHALL perform the final write, then go to WAIT_RES.
REQ-025 In WAIT_RES, resume_i=1 SHALL move the FSM to RELEASE.
REQ-026 RELEASE SHALL drive done_o=1 and core_halt_o=0 for one cycle, then return to IDLE.
REQ-027 resume_i asserted in COPY_PC, COPY_GPR or DRAIN SHALL set seq_err_o and be remembered, so that WAIT_RES proceeds to RELEASE without waiting.
REQ-028 halt_i asserted outside IDLE SHALL be ignored.
REQ-029 core_halt_o SHALL stay 1 from COPY_PC through WAIT_RES.
REQ-030 The expected counter SHALL be ADDR_WIDTH+1 bits wide so that reaching NUM_REG does not alias to 0.
REQ-031 Recovery latency from the halt command to the end of the last write SHALL be NUM_REG+2 cycles.

Reset
REQ-032 rst_ni=0 SHALL asynchronously force the FSM to IDLE and drive every output to 0.
REQ-033 rst_ni=0 SHALL clear the counter, the deferred resume and seq_err_o, including mid-copy; the copy SHALL be aborted and no further writes issued.

Structure
REQ-034 Package ft_pkg SHALL hold the replay-state enum and default ADDR_WIDTH/DATA_WIDTH constants, shared with the recovery controller.
REQ-035 Sub-module replay_seq_check SHALL hold the expected counter and the seq_err_o sticky logic; everything else SHALL stay flat.

Verification
REQ-036 A nominal recovery (halt+shift, addresses 0..31, resume) SHALL give one PC write of ckpt_pc_i, 31 rf writes to addresses 1..31 with checkpoint data, done_o pulsing once and seq_err_o=0.
REQ-037 With address 5 repeated (addresses 0..4,5,5,6..31), seq_err_o SHALL be 1 and register 5 SHALL be written twice.
REQ-038 resume_i pulsed during COPY_GPR at address 10 SHALL set seq_err_o=1 and produce done_o in the cycle after DRAIN+1 with no further resume.
REQ-039 rst_ni low at address 17 SHALL drop all outputs immediately and produce no writes; a fresh recovery afterward SHALL complete normally.
REQ-040 halt_i pulsed during WAIT_RES SHALL leave the state unchanged, and halt_i without shift_i in IDLE SHALL leave core_halt_o=0.
